// File: rtl/board_pkg.sv
// Shared board definitions: default geometry, cell encodings and the
// selector FSM state type used by board readers.
package board_pkg;

   localparam int CELL_W    = 8;
   localparam int NUM_CELLS = 9;

   localparam logic [CELL_W-1:0] EMPTY = 8'h00;
   localparam logic [CELL_W-1:0] X     = 8'h01;
   localparam logic [CELL_W-1:0] O     = 8'h02;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/board_out_slice.sv
// Valid/ready output register holding one cell word and its index.
// Loads whenever the register is empty or being drained this cycle.
module board_out_slice #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_req,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_idx,
   input  logic             out_ready,
   output logic             load_en,
   output logic [WIDTH-1:0] out_data,
   output logic [SEL_W-1:0] out_idx,
   output logic             out_valid
);

   assign load_en = !out_valid || out_ready;

   // With no request the word and index are kept; only valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
      end else if (load_en) begin
         out_valid <= load_req;
         if (load_req) begin
            out_data <= in_data;
            out_idx  <= in_idx;
         end
      end
   end

endmodule

// File: rtl/board_cell_sel.sv
// Board cell selector: direct indexed reads or an autonomous in-order
// sweep of all cells, presented through a valid/ready output register.
module board_cell_sel
   import board_pkg::*;
#(
   parameter int WIDTH  = CELL_W,
   parameter int NUM_IN = NUM_CELLS,
   parameter int SEL_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_flat,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    sel_valid,
   input  logic                    scan_start,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    scan_done,
   output logic                    sel_err
);

   localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

   state_t           state_reg;
   logic [SEL_W-1:0] idx_reg;
   logic [WIDTH-1:0] cells [NUM_IN];
   logic [SEL_W-1:0] rd_idx;
   logic [WIDTH-1:0] rd_data;
   logic             load_req;
   logic             load_en;
   logic             sel_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_cells
         assign cells[gi] = in_flat[gi*WIDTH +: WIDTH];
      end
   endgenerate

   assign sel_ok = ({1'b0, sel} < NUM_IN_W);

   always_comb begin
      rd_idx   = (state_reg == SCAN) ? idx_reg : sel;
      load_req = 1'b0;
      if (state_reg == SCAN)
         load_req = 1'b1;
      else if (state_reg == IDLE && !mode && sel_valid && sel_ok)
         load_req = 1'b1;
      rd_data = '0;
      for (int k = 0; k < NUM_IN; k++)
         if (rd_idx == SEL_W'(k))
            rd_data = cells[k];
   end

   board_out_slice #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .load_req  (load_req),
      .in_data   (rd_data),
      .in_idx    (rd_idx),
      .out_ready (out_ready),
      .load_en   (load_en),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         busy      <= 1'b0;
         scan_done <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         sel_err   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (mode && scan_start) begin
                  state_reg <= SCAN;
                  idx_reg   <= '0;
                  busy      <= 1'b1;
               end else if (!mode && sel_valid && !sel_ok) begin
                  sel_err <= 1'b1;
               end
            end
            SCAN: begin
               if (load_en) begin
                  if (idx_reg == LAST_IDX)
                     state_reg <= DRAIN;
                  else
                     idx_reg <= idx_reg + 1'b1;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_cell_sel.sv
// Directed bench for board_cell_sel: direct reads, range errors, scans,
// back-pressure, mid-scan reset and scan/direct priority.
module tb_board_cell_sel;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [71:0] in_flat;
   logic        mode = 1'b0;
   logic [3:0]  sel = '0;
   logic        sel_valid = 1'b0;
   logic        scan_start = 1'b0;
   logic [7:0]  out_data;
   logic [3:0]  out_idx;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        scan_done;
   logic        sel_err;

   int vectors = 0;
   int miscompares = 0;

   board_cell_sel #(.WIDTH(8), .NUM_IN(9), .SEL_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_flat    (in_flat),
      .mode       (mode),
      .sel        (sel),
      .sel_valid  (sel_valid),
      .scan_start (scan_start),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .scan_done  (scan_done),
      .sel_err    (sel_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 9; k++) in_flat[k*8 +: 8] = 8'(16 + k);
      #12;
      vectors++;
      if ({out_data, out_idx, out_valid, busy, scan_done, sel_err} !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_state: got data=%h idx=%0d v=%b busy=%b done=%b err=%b, want all 0",
                  out_data, out_idx, out_valid, busy, scan_done, sel_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_direct();
      mode = 1'b0; sel = 4'd4; sel_valid = 1'b1; out_ready = 1'b1;
      step();
      vectors++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 4'd4, 8'h14}) begin
         miscompares++;
         $display("FAIL direct_sel4: got v=%b idx=%0d data=%h, want v=1 idx=4 data=14", out_valid, out_idx, out_data);
      end
      sel_valid = 1'b0;
      step();
      vectors++;
      if ({out_valid, out_data} !== {1'b0, 8'h14}) begin
         miscompares++;
         $display("FAIL direct_clear: got v=%b data=%h, want v=0 data=14", out_valid, out_data);
      end
   endtask

   task automatic test_out_of_range();
      sel = 4'd9; sel_valid = 1'b1;
      step();
      vectors++;
      if ({sel_err, out_valid, out_idx, out_data} !== {1'b1, 1'b0, 4'd4, 8'h14}) begin
         miscompares++;
         $display("FAIL oor_err: got err=%b v=%b idx=%0d data=%h, want err=1 v=0 idx=4 data=14",
                  sel_err, out_valid, out_idx, out_data);
      end
      sel_valid = 1'b0;
      step();
      vectors++;
      if ({sel_err, out_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL oor_pulse: got err=%b v=%b, want err=0 v=0", sel_err, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; sel = 4'd1; sel_valid = 1'b1;
      step();
      vectors++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 4'd1, 8'h11}) begin
         miscompares++;
         $display("FAIL b2b_load1: got v=%b idx=%0d data=%h, want v=1 idx=1 data=11", out_valid, out_idx, out_data);
      end
      sel = 4'd2;
      step();
      vectors++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 4'd1, 8'h11}) begin
         miscompares++;
         $display("FAIL b2b_hold: got v=%b idx=%0d data=%h, want v=1 idx=1 data=11", out_valid, out_idx, out_data);
      end
      out_ready = 1'b1;
      step();
      vectors++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 4'd2, 8'h12}) begin
         miscompares++;
         $display("FAIL b2b_next: got v=%b idx=%0d data=%h, want v=1 idx=2 data=12", out_valid, out_idx, out_data);
      end
      sel_valid = 1'b0;
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_drain: got v=%b, want v=0", out_valid);
      end
   endtask

   task automatic test_scan();
      mode = 1'b1; scan_start = 1'b1; out_ready = 1'b1;
      step();
      scan_start = 1'b0;
      vectors++;
      if ({busy, out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL scan_start: got busy=%b v=%b, want busy=1 v=0", busy, out_valid);
      end
      for (int n = 0; n < 9; n++) begin
         step();
         vectors++;
         if ({out_valid, busy, out_idx, out_data} !== {1'b1, 1'b1, 4'(n), 8'(16 + n)}) begin
            miscompares++;
            $display("FAIL scan_word%0d: got v=%b busy=%b idx=%0d data=%h, want v=1 busy=1 idx=%0d data=%h",
                     n, out_valid, busy, out_idx, out_data, n, 8'(16 + n));
         end
      end
      step();
      vectors++;
      if ({scan_done, busy, out_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL scan_done: got done=%b busy=%b v=%b, want done=1 busy=0 v=0", scan_done, busy, out_valid);
      end
      step();
      vectors++;
      if ({scan_done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL scan_done_pulse: got done=%b busy=%b, want done=0 busy=0", scan_done, busy);
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      int stall = 0;
      bit done = 0;
      mode = 1'b1; scan_start = 1'b1; out_ready = 1'b1;
      step();
      scan_start = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         step();
         if (scan_done) begin
            done = 1;
         end else if (out_valid) begin
            if (out_idx == 4'd3 && stall < 3) begin
               vectors++;
               if (out_data !== 8'h13) begin
                  miscompares++;
                  $display("FAIL bp_hold%0d: got data=%h, want 13", stall, out_data);
               end
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = 1'b1;
               vectors++;
               if ({out_idx, out_data} !== {4'(n), 8'(16 + n)}) begin
                  miscompares++;
                  $display("FAIL bp_word%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                           n, out_idx, out_data, n, 8'(16 + n));
               end
               n++;
            end
         end
      end
      out_ready = 1'b1;
      vectors++;
      if (!(done && n == 9 && stall == 3)) begin
         miscompares++;
         $display("FAIL bp_total: got done=%b words=%0d stalls=%0d, want done=1 words=9 stalls=3", done, n, stall);
      end
   endtask

   task automatic test_reset_mid_scan();
      int guard = 0;
      int n = 0;
      bit done = 0;
      mode = 1'b1; scan_start = 1'b1; out_ready = 1'b1;
      step();
      scan_start = 1'b0;
      while (!(out_valid && out_idx == 4'd5) && guard < 30) begin
         step();
         guard++;
      end
      vectors++;
      if (guard >= 30) begin
         miscompares++;
         $display("FAIL rstmid_reach: got idx=%0d v=%b, want idx=5 v=1 within 30 cycles", out_idx, out_valid);
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({out_data, out_idx, out_valid, busy, scan_done, sel_err} !== 16'h0) begin
         miscompares++;
         $display("FAIL rstmid_async: got data=%h idx=%0d v=%b busy=%b, want all 0", out_data, out_idx, out_valid, busy);
      end
      #1 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++;
         if ({scan_done, busy, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstmid_idle%0d: got done=%b busy=%b v=%b, want 0 0 0", c, scan_done, busy, out_valid);
         end
      end
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      step();
      vectors++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 4'd0, 8'h10}) begin
         miscompares++;
         $display("FAIL rstmid_restart: got v=%b idx=%0d data=%h, want v=1 idx=0 data=10", out_valid, out_idx, out_data);
      end
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         if (scan_done) done = 1;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL rstmid_finish: got done=0, want scan_done within 20 cycles");
      end
      n = 0;
   endtask

   task automatic test_priority();
      mode = 1'b1; scan_start = 1'b1; sel = 4'd2; sel_valid = 1'b1; out_ready = 1'b1;
      step();
      scan_start = 1'b0;
      mode = 1'b0;
      vectors++;
      if ({busy, out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL prio_start: got busy=%b v=%b idx=%0d, want busy=1 v=0", busy, out_valid, out_idx);
      end
      for (int n = 0; n < 9; n++) begin
         step();
         vectors++;
         if ({out_valid, out_idx, out_data} !== {1'b1, 4'(n), 8'(16 + n)}) begin
            miscompares++;
            $display("FAIL prio_word%0d: got v=%b idx=%0d data=%h, want v=1 idx=%0d data=%h",
                     n, out_valid, out_idx, out_data, n, 8'(16 + n));
         end
      end
      sel_valid = 1'b0;
      step();
      vectors++;
      if ({scan_done, busy, out_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL prio_done: got done=%b busy=%b v=%b, want done=1 busy=0 v=0", scan_done, busy, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_out_of_range();
      test_back_to_back();
      test_scan();
      test_backpressure();
      test_reset_mid_scan();
      test_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
